// File: rtl/buf_rd_arbiter.sv
// Two-requester read arbiter in front of one single-port buffer. Each return is
// routed back to the requester that issued it through an in-flight tag pipeline.
module buf_rd_arbiter #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  prio_mode,
  input  logic                  req0_rd_en,
  input  logic [ADDR_WIDTH-1:0] req0_rd_addr,
  output logic [DATA_WIDTH-1:0] req0_rd_data,
  output logic                  req0_rd_valid,
  input  logic                  req1_rd_en,
  input  logic [ADDR_WIDTH-1:0] req1_rd_addr,
  output logic [DATA_WIDTH-1:0] req1_rd_data,
  output logic                  req1_rd_valid,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_rd_valid,
  output logic                  grant_owner,
  output logic                  orphan_err
);

  localparam int unsigned WAIT_WIDTH = 8;
  localparam logic [WAIT_WIDTH-1:0] WAIT_MAX   = {WAIT_WIDTH{1'b1}};
  localparam logic [WAIT_WIDTH-1:0] STARVE_THR = WAIT_WIDTH'(STARVE_LIMIT);

  // One in-flight read: live = a read was issued, discard = flushed by clear.
  typedef struct packed {
    logic live;
    logic discard;
    logic owner;
  } tag_t;

  logic [WAIT_WIDTH-1:0] wait1;
  logic                  last_grant;
  logic                  prio_mode_q;
  tag_t                  tag_q [READ_LATENCY];
  tag_t                  tag_d [READ_LATENCY];

  logic                  gnt_c;
  logic                  owner_c;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic                  mode_chg_c;
  tag_t                  out_tag_c;
  logic                  deliver_c;
  logic                  err_c;

  assign mode_chg_c = prio_mode ^ prio_mode_q;

  // Grant decision: round-robin or fixed priority with a starvation override.
  always_comb begin
    gnt_c   = 1'b0;
    owner_c = 1'b0;
    if (!clear) begin
      if (req0_rd_en && req1_rd_en) begin
        gnt_c = 1'b1;
        if (prio_mode) begin
          owner_c = (wait1 >= STARVE_THR);
        end else begin
          owner_c = ~last_grant;
        end
      end else if (req0_rd_en) begin
        gnt_c   = 1'b1;
        owner_c = 1'b0;
      end else if (req1_rd_en) begin
        gnt_c   = 1'b1;
        owner_c = 1'b1;
      end
    end
    addr_c = owner_c ? req1_rd_addr : req0_rd_addr;
  end

  // Next tag pipeline contents; clear marks every live entry for silent discard.
  always_comb begin
    tag_d[0].live    = mem_rd_en;
    tag_d[0].discard = mem_rd_en & clear;
    tag_d[0].owner   = grant_owner;
    for (int i = 1; i < READ_LATENCY; i++) begin
      tag_d[i]         = tag_q[i-1];
      tag_d[i].discard = tag_q[i-1].discard | (clear & tag_q[i-1].live);
    end
  end

  // Output stage: deliver matching returns, flag mismatches.
  always_comb begin
    out_tag_c = tag_q[READ_LATENCY-1];
    deliver_c = !clear && out_tag_c.live && !out_tag_c.discard && mem_rd_valid;
    err_c     = !clear && ((out_tag_c.live && !out_tag_c.discard && !mem_rd_valid) ||
                           (!out_tag_c.live && mem_rd_valid));
  end

  // Tag pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  // Arbitration state: starvation counter, round-robin pointer, mode history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait1       <= '0;
      last_grant  <= 1'b1;
      prio_mode_q <= 1'b0;
    end else begin
      prio_mode_q <= prio_mode;
      if (clear || mode_chg_c || !req1_rd_en || (gnt_c && owner_c)) begin
        wait1 <= '0;
      end else if (prio_mode && (wait1 != WAIT_MAX)) begin
        wait1 <= wait1 + WAIT_WIDTH'(1);
      end
      if (clear) begin
        last_grant <= 1'b1;
      end else if (gnt_c) begin
        last_grant <= owner_c;
      end
    end
  end

  // Registered buffer read strobe, address and owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      grant_owner <= 1'b0;
    end else begin
      mem_rd_en <= gnt_c;
      if (gnt_c) begin
        mem_rd_addr <= addr_c;
        grant_owner <= owner_c;
      end
    end
  end

  // Registered return path and sticky protocol error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req0_rd_valid <= 1'b0;
      req1_rd_valid <= 1'b0;
      req0_rd_data  <= '0;
      req1_rd_data  <= '0;
      orphan_err    <= 1'b0;
    end else begin
      req0_rd_valid <= deliver_c & ~out_tag_c.owner;
      req1_rd_valid <= deliver_c & out_tag_c.owner;
      if (deliver_c && !out_tag_c.owner) begin
        req0_rd_data <= mem_rd_data;
      end
      if (deliver_c && out_tag_c.owner) begin
        req1_rd_data <= mem_rd_data;
      end
      if (clear) begin
        orphan_err <= 1'b0;
      end else if (err_c) begin
        orphan_err <= 1'b1;
      end
    end
  end

endmodule
